// File: rtl/wb_arbiter.sv
// Writeback/commit stage: per-channel result FIFOs, round-robin arbitration onto the
// single regfile write port, and a one-cycle-delayed commit record for difftest.
module wb_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*5-1:0]      in_rd,
    input  logic [NUM_CH-1:0]        in_need_to_wb,
    input  logic [NUM_CH-1:0]        in_mmio,
    input  logic [NUM_CH*DATA_W-1:0] in_result,
    input  logic [NUM_CH*64-1:0]     in_pc,
    input  logic [NUM_CH*32-1:0]     in_instr,
    output logic                     regfile_write_valid,
    output logic [4:0]               regfile_write_rd,
    output logic [DATA_W-1:0]        regfile_write_data,
    output logic                     commit_valid,
    output logic                     commit_rfwen,
    output logic                     commit_skip,
    output logic [4:0]               commit_rd,
    output logic [63:0]              commit_pc,
    output logic [31:0]              commit_instr,
    output logic [31:0]              conflict_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic [4:0]        rd;
        logic              need_to_wb;
        logic              mmio;
        logic [DATA_W-1:0] result;
        logic [63:0]       pc;
        logic [31:0]       instr;
    } entry_t;

    typedef struct packed {
        logic              valid;
        logic              rf_valid;
        logic              mmio;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
        logic [63:0]       pc;
        logic [31:0]       instr;
    } wb_t;

    typedef struct packed {
        logic        valid;
        logic        rfwen;
        logic        skip;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [31:0] instr;
    } commit_t;

    entry_t             fifo_mem_q [NUM_CH][FIFO_DEPTH];
    entry_t             in_entry   [NUM_CH];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_CH], rd_ptr_d [NUM_CH];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_CH], wr_ptr_d [NUM_CH];
    logic [CNT_W-1:0]   count_q  [NUM_CH], count_d  [NUM_CH];
    logic [NUM_CH-1:0]  push, req, grant;
    logic               grant_valid;
    logic [RR_W-1:0]    grant_idx, rr_ptr_q, rr_ptr_d;
    int                 idx, n_req;
    entry_t             head;
    wb_t                wb_q, wb_d;
    commit_t            cm_q, cm_d;
    logic [31:0]        conflict_cnt_q, conflict_cnt_d;

    // Ready depends only on registered count, so a full FIFO refuses even while popping.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            in_entry[c] = '{rd:         in_rd[c*5 +: 5],
                            need_to_wb: in_need_to_wb[c],
                            mmio:       in_mmio[c],
                            result:     in_result[c*DATA_W +: DATA_W],
                            pc:         in_pc[c*64 +: 64],
                            instr:      in_instr[c*32 +: 32]};
            in_ready[c]  = (count_q[c] != CNT_W'(FIFO_DEPTH));
            push[c]      = in_valid[c] & in_ready[c];
            req[c]       = (count_q[c] != '0);
        end
    end

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        n_req       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (req[idx] && !grant_valid) begin
                grant_valid = 1'b1;
                grant_idx   = RR_W'(idx);
            end
            n_req = n_req + int'(req[i]);
        end
        if (grant_valid) grant[grant_idx] = 1'b1;
        head = fifo_mem_q[grant_idx][rd_ptr_q[grant_idx]];
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = push[c]  ? wr_ptr_q[c] + PTR_W'(1) : wr_ptr_q[c];
            rd_ptr_d[c] = grant[c] ? rd_ptr_q[c] + PTR_W'(1) : rd_ptr_q[c];
            count_d[c]  = count_q[c] + CNT_W'(push[c]) - CNT_W'(grant[c]);
        end

        rr_ptr_d = rr_ptr_q;
        if (grant_valid)
            rr_ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + RR_W'(1);

        conflict_cnt_d = conflict_cnt_q;
        if (n_req >= 2 && conflict_cnt_q != 32'hFFFF_FFFF)
            conflict_cnt_d = conflict_cnt_q + 32'd1;

        // Without a grant the strobes drop while rd/data/pc/instr keep their last value.
        wb_d          = wb_q;
        wb_d.valid    = grant_valid;
        wb_d.rf_valid = grant_valid & head.need_to_wb & ~head.mmio;
        wb_d.mmio     = grant_valid & head.mmio;
        if (grant_valid) begin
            wb_d.rd    = head.rd;
            wb_d.data  = head.result;
            wb_d.pc    = head.pc;
            wb_d.instr = head.instr;
        end

        cm_d = '{valid: wb_q.valid, rfwen: wb_q.rf_valid, skip: wb_q.mmio,
                 rd: wb_q.rd, pc: wb_q.pc, instr: wb_q.instr};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            rr_ptr_q       <= '0;
            conflict_cnt_q <= '0;
            wb_q           <= '0;
            cm_q           <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr_q[c] <= rd_ptr_d[c];
                wr_ptr_q[c] <= wr_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
            rr_ptr_q       <= rr_ptr_d;
            conflict_cnt_q <= conflict_cnt_d;
            wb_q           <= wb_d;
            cm_q           <= cm_d;
        end
    end

    // NOTE: storage is not reset; zeroed counts make stale entries unreachable.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++)
            if (push[c]) fifo_mem_q[c][wr_ptr_q[c]] <= in_entry[c];
    end

    assign regfile_write_valid = wb_q.rf_valid;
    assign regfile_write_rd    = wb_q.rd;
    assign regfile_write_data  = wb_q.data;
    assign commit_valid        = cm_q.valid;
    assign commit_rfwen        = cm_q.rfwen;
    assign commit_skip         = cm_q.skip;
    assign commit_rd           = cm_q.rd;
    assign commit_pc           = cm_q.pc;
    assign commit_instr        = cm_q.instr;
    assign conflict_cnt        = conflict_cnt_q;

endmodule
